mmio_memory_controller: RTL and testbench

- Parametrised successor to the core's memory controller: one request/response port from the RISC-V core.
- Decodes each request to one of three targets: byte-addressable on-chip RAM, debounced switch inputs, or an LED output register.
- Adds a valid/ready handshake, byte enables, configurable RAM depth and read latency, IO widths, switch debouncing, a sticky switch-change flag and error responses.
- Sits between the core's load/store unit and board IO.

---
 rtl/memory_controller_pkg.sv | 34 +++
 rtl/sw_debounce.sv | 41 ++++
 rtl/mmio_memory_controller.sv | 146 ++++++++++++++
 tb/tb_mmio_memory_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_controller_pkg.sv
// Address map, FSM/region encodings and request decode shared by the MMIO memory controller.
package memory_controller_pkg;

  localparam logic [31:0] RAM_BASE       = 32'h0000_0000;
  localparam logic [31:0] SW_DATA_ADDR   = 32'h8000_0000;
  localparam logic [31:0] LED_DATA_ADDR  = 32'h8000_0004;
  localparam logic [31:0] SW_STATUS_ADDR = 32'h8000_0008;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef enum logic [2:0] {REG_RAM, REG_SW, REG_LED, REG_STAT, REG_NONE} region_e;

  typedef struct packed {
    region_e region;
    logic    err;
  } decode_t;

  // Any error maps to REG_NONE so no target can be written by a rejected request.
  function automatic decode_t decode(input logic [31:0] addr, input logic we,
                                     input logic [31:0] ram_bytes);
    decode_t d;
    d.region = REG_NONE;
    d.err    = 1'b1;
    if (addr[1:0] == 2'b00) begin
      if ((addr - RAM_BASE) < ram_bytes)    d.region = REG_RAM;
      else if (addr == SW_DATA_ADDR && !we) d.region = REG_SW;
      else if (addr == LED_DATA_ADDR)       d.region = REG_LED;
      else if (addr == SW_STATUS_ADDR)      d.region = REG_STAT;
      d.err = (d.region == REG_NONE);
    end
    return d;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stability counter; commits the switch vector once it has held
// still for DEBOUNCE_CYCLES consecutive samples.
module sw_debounce #(
  parameter int NUM_SW          = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_SW-1:0] sw_stable,
  output logic              sw_commit_pulse
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sync1_q, sync2_q, prev_q, stable_q;
  logic [CW-1:0]     cnt_q;

  // A saturated counter alone is not enough: the vector must also not have moved this cycle.
  assign sw_commit_pulse = (cnt_q == CNT_MAX) && (sync2_q == prev_q) && (sync2_q != stable_q);
  assign sw_stable       = stable_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q != prev_q)   cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
      if (sw_commit_pulse) stable_q <= sync2_q;
    end
  end

endmodule

// File: rtl/mmio_memory_controller.sv
// Single-port MMIO controller: routes core requests to byte-lane RAM, debounced switches
// and an LED register. RD_LATENCY=2 adds a WAIT cycle that holds data in an output register.
module mmio_memory_controller
  import memory_controller_pkg::*;
#(
  parameter int RAM_WORDS       = 4096,
  parameter int RD_LATENCY      = 1,
  parameter int NUM_SW          = 16,
  parameter int NUM_LED         = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               req_valid_in,
  output logic               req_ready_out,
  input  logic [31:0]        addr_in,
  input  logic               we_in,
  input  logic [3:0]         be_in,
  input  logic [31:0]        wr_data_in,
  output logic               rsp_valid_out,
  output logic               rsp_err_out,
  output logic [31:0]        rd_data_out,
  input  logic [NUM_SW-1:0]  sw_in,
  output logic [NUM_LED-1:0] led_out
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  state_e             state_q;
  logic               req_ready_q, rsp_valid_q, rsp_err_q, pipe_err_q, sw_changed_q;
  logic [31:0]        rd_data_q, pipe_data_q, rd_data_d;
  logic [NUM_LED-1:0] led_q;
  logic [3:0][7:0]    ram [RAM_WORDS];
  logic [NUM_SW-1:0]  sw_stable;
  logic               sw_commit;
  decode_t            dec;
  logic               accept;
  logic [AW-1:0]      ram_idx;

  sw_debounce #(
    .NUM_SW          (NUM_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sw_in           (sw_in),
    .sw_stable       (sw_stable),
    .sw_commit_pulse (sw_commit)
  );

  assign dec     = decode(addr_in, we_in, RAM_BYTES);
  assign accept  = req_valid_in && req_ready_q && !rst_in;
  assign ram_idx = addr_in[AW+1:2];

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    rd_data_d = '0;
    if (!we_in) begin
      unique case (dec.region)
        REG_RAM:  rd_data_d = ram[ram_idx];
        REG_SW:   rd_data_d = 32'(sw_stable);
        REG_LED:  rd_data_d = 32'(led_q);
        REG_STAT: rd_data_d = {31'b0, sw_changed_q};
        default:  rd_data_d = '0;
      endcase
    end
  end

  // NOTE: RAM carries no reset so the array can map onto block RAM; contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (accept && we_in && dec.region == REG_RAM) begin
      for (int b = 0; b < 4; b++) begin
        if (be_in[b]) ram[ram_idx][b] <= wr_data_in[8*b +: 8];
      end
    end
  end

  // A commit and a W1C clear on the same edge leave the flag set.
  always_ff @(posedge clk_in) begin
    if (rst_in)         sw_changed_q <= 1'b0;
    else if (sw_commit) sw_changed_q <= 1'b1;
    else if (accept && we_in && dec.region == REG_STAT && be_in[0] && wr_data_in[0])
      sw_changed_q <= 1'b0;
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values, which is also
  // why a read in the switch commit cycle returns the previously committed value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_data_q   <= '0;
      pipe_data_q <= '0;
      pipe_err_q  <= 1'b0;
      led_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (we_in && dec.region == REG_LED) begin
              for (int i = 0; i < NUM_LED; i++) begin
                if (be_in[i/8]) led_q[i] <= wr_data_in[i];
              end
            end
            pipe_data_q <= rd_data_d;
            pipe_err_q  <= dec.err;
            req_ready_q <= 1'b0;
            if (RD_LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= dec.err;
              rd_data_q   <= rd_data_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= pipe_err_q;
          rd_data_q   <= pipe_data_q;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_out = req_ready_q;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_err_out   = rsp_err_q;
  assign rd_data_out   = rd_data_q;
  assign led_out       = led_q;

endmodule

// File: tb/tb_mmio_memory_controller.sv
// Scoreboard bench: each issued request pushes its modelled response; a negedge monitor
// pops and compares error, data and arrival cycle whenever rsp_valid_out pulses.
module tb_mmio_memory_controller;

  localparam int          RAM_WORDS = 256;
  localparam int          RD_LAT    = 2;
  localparam int          DEB       = 8;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] A_SW      = 32'h8000_0000;
  localparam logic [31:0] A_LED     = 32'h8000_0004;
  localparam logic [31:0] A_STAT    = 32'h8000_0008;

  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [15:0] sw = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rd_data;
  logic [15:0] led;

  mmio_memory_controller #(
    .RAM_WORDS       (RAM_WORDS),
    .RD_LATENCY      (RD_LAT),
    .NUM_SW          (16),
    .NUM_LED         (16),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .addr_in       (addr),
    .we_in         (we),
    .be_in         (be),
    .wr_data_in    (wdata),
    .rsp_valid_out (rsp_valid),
    .rsp_err_out   (rsp_err),
    .rd_data_out   (rd_data),
    .sw_in         (sw),
    .led_out       (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: plain arrays updated in request order.
  logic [31:0] mem_m [RAM_WORDS];
  logic [3:0]  bv_m  [RAM_WORDS];
  logic [15:0] led_m = '0, sw_m = '0;
  logic        chg_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, output logic err, output logic [31:0] data);
    err  = 1'b0;
    data = '0;
    if (a[1:0] != 2'b00) err = 1'b1;
    else if (a < RAM_BYTES) begin
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) begin
            mem_m[a >> 2][8*i +: 8] = d[8*i +: 8];
            bv_m[a >> 2][i] = 1'b1;
          end
        end
      end else data = mem_m[a >> 2];
    end else if (a == A_SW) begin
      if (w) err = 1'b1;
      else   data = {16'h0, sw_m};
    end else if (a == A_LED) begin
      if (w) begin
        for (int i = 0; i < 16; i++) if (b[i/8]) led_m[i] = d[i];
      end else data = {16'h0, led_m};
    end else if (a == A_STAT) begin
      if (w) begin
        if (b[0] && d[0]) chg_m = 1'b0;
      end else data = {31'h0, chg_m};
    end else err = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the response when the port is idle again.
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
    exp_t e;
    int   n;
    n = 0;
    addr = a; we = w; be = b; wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got ready=0 want ready=1 (addr %h)", a);
      req_valid = 1'b0;
      return;
    end
    model(a, w, b, d, e.err, e.data);
    e.due = cyc + RD_LAT;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < RD_LAT; k++) begin
      @(negedge clk);
      check("ready_busy", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 want 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_data", rd_data, e.data);
        check("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          op, n;
    int unsigned wi;
    logic [31:0] d;
    logic [3:0]  b;

    for (int i = 0; i < RAM_WORDS; i++) bv_m[i] = 4'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // RAM full-word and byte-lane writes
    issue(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    issue(32'h10, 1'b1, 4'b0001, 32'h0000_00AA);
    issue(32'h10, 1'b0, 4'hF, 32'h0);

    // LED register keeps only NUM_LED bits
    issue(A_LED, 1'b1, 4'hF, 32'h0001_FFFF);
    issue(A_LED, 1'b0, 4'h0, 32'h0);
    check("led_out", 32'(led), 32'h0000_FFFF);

    // Bouncing switches, then a steady 0x00A5
    for (int i = 0; i < 5; i++) begin
      sw = (i % 2 == 0) ? 16'h00A5 : 16'h0000;
      @(negedge clk);
    end
    sw = 16'h00A5;
    issue(A_SW, 1'b0, 4'h0, 32'h0);
    issue(A_STAT, 1'b0, 4'h0, 32'h0);
    repeat (20) @(negedge clk);
    sw_m  = 16'h00A5;
    chg_m = 1'b1;
    issue(A_SW, 1'b0, 4'h0, 32'h0);
    issue(A_STAT, 1'b0, 4'h0, 32'h0);
    issue(A_STAT, 1'b1, 4'h1, 32'h1);
    issue(A_STAT, 1'b0, 4'h0, 32'h0);

    // Error responses and boundaries
    issue(32'h2, 1'b0, 4'h0, 32'h0);
    issue(32'h4000_0000, 1'b0, 4'h0, 32'h0);
    issue(A_SW, 1'b1, 4'hF, 32'h1234_5678);
    issue(32'h12, 1'b1, 4'hF, 32'h1111_1111);
    issue(RAM_BYTES, 1'b1, 4'hF, 32'h2222_2222);
    issue(32'h10, 1'b1, 4'h0, 32'h3333_3333);
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    issue(A_LED, 1'b0, 4'h0, 32'h0);
    check("led_after_err", 32'(led), 32'h0000_FFFF);
    issue(RAM_BYTES - 4, 1'b1, 4'hF, 32'hCAFE_F00D);
    issue(RAM_BYTES - 4, 1'b0, 4'h0, 32'h0);

    // Randomised traffic against the reference model
    for (int t = 0; t < 150; t++) begin
      op = $urandom_range(0, 9);
      wi = ($urandom_range(0, 7) == 0) ? RAM_WORDS - 1 : $urandom_range(0, 15);
      d  = $urandom;
      b  = 4'($urandom);
      case (op)
        0, 1, 2: begin
          if (bv_m[wi] != 4'hF) b = 4'hF;
          issue(32'(wi * 4), 1'b1, b, d);
        end
        3, 4: begin
          if (bv_m[wi] == 4'hF) issue(32'(wi * 4), 1'b0, b, d);
          else                  issue(A_LED, 1'b0, b, d);
        end
        5: issue(A_LED, 1'($urandom_range(0, 1)), b, d);
        6: issue(A_STAT, 1'($urandom_range(0, 1)), b, d);
        7: issue(A_SW, 1'b0, b, d);
        8: begin
          case ($urandom_range(0, 3))
            0: issue(32'(wi * 4) + 32'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), b, d);
            1: issue(32'h4000_0000 | (d & 32'hFFFF_FFFC), 1'($urandom_range(0, 1)), b, d);
            2: issue(A_SW, 1'b1, b, d);
            default: issue(32'h8000_000C, 1'($urandom_range(0, 1)), b, d);
          endcase
        end
        default: issue(32'(wi * 4), 1'b1, 4'h0, d);
      endcase
    end
    check("led_after_random", 32'(led), 32'(led_m));

    // Reset during the WAIT cycle of a read, with a request held during reset
    addr = 32'h10; we = 1'b0; be = 4'h0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_no_rsp0", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    addr = A_LED; we = 1'b1; be = 4'hF; wdata = 32'h0000_1234; req_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_no_rsp1", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_no_rsp2", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    led_m = '0;
    sw_m  = '0;
    chg_m = 1'b0;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_led", 32'(led), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    issue(A_LED, 1'b0, 4'h0, 32'h0);
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    repeat (20) @(negedge clk);
    sw_m  = 16'h00A5;
    chg_m = 1'b1;
    issue(A_SW, 1'b0, 4'h0, 32'h0);
    issue(A_STAT, 1'b0, 4'h0, 32'h0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_missing: got %0d pending want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
